// File: rtl/arc4_encrypt_if.sv
// Start handshake plus S/pt/ct memory ports of the ARC4 encryption engine.
// master: requester and memories; slave: the engine.
interface arc4_encrypt_if #(
    parameter int KEY_BYTES = 3
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;
    logic [7:0]             pt_addr;
    logic [7:0]             pt_rddata;
    logic [7:0]             ct_addr;
    logic [7:0]             ct_wrdata;
    logic                   ct_wren;

    modport master (
        output en, key, s_rddata, pt_rddata,
        input  rdy, s_addr, s_wrdata, s_wren,
        input  pt_addr, ct_addr, ct_wrdata, ct_wren
    );

    modport slave (
        input  en, key, s_rddata, pt_rddata,
        output rdy, s_addr, s_wrdata, s_wren,
        output pt_addr, ct_addr, ct_wrdata, ct_wren
    );
endinterface

// File: rtl/arc4_encrypt.sv
// ARC4 encryption engine: INIT and KSA on external S memory, then PRGA
// turns length-prefixed plaintext into length-prefixed ciphertext.
module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input logic           clk,
    input logic           rst,
    arc4_encrypt_if.slave bus
);
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [4:0] IDLE = 5'd0;
    localparam logic [4:0] INIT = 5'd1;
    localparam logic [4:0] KP1  = 5'd2;
    localparam logic [4:0] KP2  = 5'd3;
    localparam logic [4:0] KA   = 5'd4;
    localparam logic [4:0] KB   = 5'd5;
    localparam logic [4:0] KC   = 5'd6;
    localparam logic [4:0] KD   = 5'd7;
    localparam logic [4:0] RL1  = 5'd8;
    localparam logic [4:0] RL2  = 5'd9;
    localparam logic [4:0] WL   = 5'd10;
    localparam logic [4:0] P1   = 5'd11;
    localparam logic [4:0] P2   = 5'd12;
    localparam logic [4:0] P3   = 5'd13;
    localparam logic [4:0] P4   = 5'd14;
    localparam logic [4:0] P5   = 5'd15;
    localparam logic [4:0] P6   = 5'd16;
    localparam logic [4:0] P7   = 5'd17;

    logic [4:0]             state;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [KW-1:0]          kidx;
    logic [7:0]             i, j, si, sj, sn, len;
    logic [8:0]             k;
    logic [7:0]             s_addr, s_wrdata, pt_addr, ct_addr, ct_wrdata;
    logic                   s_wren, ct_wren;

    logic [KW-1:0] kidx_nx, kidx_sel;
    logic [7:0]    kb, i_nx, fwd, j_add, jn, jp, t, pad;

    assign bus.rdy       = rdy;
    assign bus.s_addr    = s_addr;
    assign bus.s_wrdata  = s_wrdata;
    assign bus.s_wren    = s_wren;
    assign bus.pt_addr   = pt_addr;
    assign bus.ct_addr   = ct_addr;
    assign bus.ct_wrdata = ct_wrdata;
    assign bus.ct_wren   = ct_wren;

    // S[i+1] is prefetched before the swap; forward when the swap hit it
    always_comb begin
        i_nx     = i + 8'd1;
        kidx_nx  = (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
        kidx_sel = (state == KD) ? kidx_nx : kidx;
        kb       = key_q[8*(KEY_BYTES-1) +: 8];
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (kidx_sel == KW'(n)) kb = key_q[8*(KEY_BYTES-1-n) +: 8];
        end
        fwd   = (i_nx == j) ? si : sn;
        j_add = (state == KD) ? fwd : bus.s_rddata;
        jn    = j + j_add + kb;
        jp    = j + bus.s_rddata;
        t     = si + sj;
        pad   = (t == j) ? si : ((t == i) ? sj : bus.s_rddata);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy       <= 1'b0;
            key_q     <= '0;
            kidx      <= '0;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            sj        <= '0;
            sn        <= '0;
            len       <= '0;
            k         <= '0;
            s_addr    <= '0;
            s_wrdata  <= '0;
            s_wren    <= 1'b0;
            pt_addr   <= '0;
            ct_addr   <= '0;
            ct_wrdata <= '0;
            ct_wren   <= 1'b0;
        end else begin
            s_wren  <= 1'b0;
            ct_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rdy) begin
                        rdy <= 1'b1;
                    end else if (bus.en) begin
                        rdy      <= 1'b0;
                        key_q    <= bus.key;
                        s_addr   <= 8'd0;
                        s_wrdata <= 8'd0;
                        s_wren   <= 1'b1;
                        i        <= 8'd1;
                        j        <= 8'd0;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (i == 8'd0) begin
                        s_addr <= 8'd0;
                        kidx   <= '0;
                        state  <= KP1;
                    end else begin
                        s_addr   <= i;
                        s_wrdata <= i;
                        s_wren   <= 1'b1;
                        i        <= i_nx;
                    end
                end
                KP1: state <= KP2;
                KP2: begin
                    si     <= bus.s_rddata;
                    j      <= jn;
                    s_addr <= jn;
                    state  <= KA;
                end
                KA: begin
                    s_addr <= i_nx;
                    state  <= KB;
                end
                KB: begin
                    sj       <= bus.s_rddata;
                    s_addr   <= i;
                    s_wrdata <= bus.s_rddata;
                    s_wren   <= 1'b1;
                    state    <= KC;
                end
                KC: begin
                    sn       <= bus.s_rddata;
                    s_addr   <= j;
                    s_wrdata <= si;
                    s_wren   <= 1'b1;
                    state    <= KD;
                end
                KD: begin
                    if (i == 8'hFF) begin
                        pt_addr <= 8'd0;
                        state   <= RL1;
                    end else begin
                        si     <= fwd;
                        j      <= jn;
                        s_addr <= jn;
                        i      <= i_nx;
                        kidx   <= kidx_nx;
                        state  <= KA;
                    end
                end
                RL1: state <= RL2;
                RL2: begin
                    len       <= bus.pt_rddata;
                    ct_addr   <= 8'd0;
                    ct_wrdata <= bus.pt_rddata;
                    ct_wren   <= 1'b1;
                    i         <= 8'd0;
                    j         <= 8'd0;
                    k         <= 9'd1;
                    state     <= WL;
                end
                WL: begin
                    if (len == 8'd0) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        s_addr  <= i_nx;
                        i       <= i_nx;
                        pt_addr <= k[7:0];
                        state   <= P1;
                    end
                end
                P1: state <= P2;
                P2: begin
                    si     <= bus.s_rddata;
                    j      <= jp;
                    s_addr <= jp;
                    state  <= P3;
                end
                P3: state <= P4;
                // pad read is issued before the swap lands; pad forwards it
                P4: begin
                    sj     <= bus.s_rddata;
                    s_addr <= si + bus.s_rddata;
                    state  <= P5;
                end
                P5: begin
                    s_addr   <= i;
                    s_wrdata <= sj;
                    s_wren   <= 1'b1;
                    state    <= P6;
                end
                P6: begin
                    s_addr    <= j;
                    s_wrdata  <= si;
                    s_wren    <= 1'b1;
                    ct_addr   <= k[7:0];
                    ct_wrdata <= bus.pt_rddata ^ pad;
                    ct_wren   <= 1'b1;
                    state     <= P7;
                end
                P7: begin
                    if (k == {1'b0, len}) begin
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        k       <= k + 9'd1;
                        s_addr  <= i_nx;
                        i       <= i_nx;
                        pt_addr <= k[7:0] + 8'd1;
                        state   <= P1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arc4_encrypt.sv
// Directed bench for arc4_encrypt with S/pt/ct memory models.
// Known ARC4 vectors plus a plain reference of the cipher.
module tb_arc4_encrypt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arc4_encrypt_if bus ();

    arc4_encrypt dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] s_mem  [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] ref_s  [256];
    logic [7:0] ref_ct [256];
    logic [7:0] ref_ks [256];

    logic [7:0] exp_std [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8,
                                 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    int checks = 0;
    int errors = 0;
    int s_wr_cnt = 0, ct_wr_cnt = 0, init_good = 0, ct_order_err = 0;
    int s_base = 0, ct_base = 0, init0 = 0, ord0 = 0;

    always @(posedge clk) begin
        if (bus.s_wren) begin
            if (s_wr_cnt - s_base < 256 &&
                int'(bus.s_addr) == s_wr_cnt - s_base &&
                int'(bus.s_wrdata) == s_wr_cnt - s_base)
                init_good++;
            s_mem[bus.s_addr] <= bus.s_wrdata;
            s_wr_cnt++;
        end
        if (bus.ct_wren) begin
            if (int'(bus.ct_addr) != ct_wr_cnt - ct_base) ct_order_err++;
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
            ct_wr_cnt++;
        end
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.pt_rddata <= pt_mem[bus.pt_addr];
    end

    task automatic load_pt(input string s);
        pt_mem[0] = 8'(s.len());
        for (int n = 0; n < s.len(); n++) pt_mem[n+1] = s[n];
    endtask

    task automatic model(input logic [23:0] kv);
        logic [7:0] s [256];
        logic [7:0] a, b, t, tmp;
        int L;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        b = 8'd0;
        for (int n = 0; n < 256; n++) begin
            b = b + s[n] + kv[23-8*(n%3) -: 8];
            tmp = s[n]; s[n] = s[b]; s[b] = tmp;
        end
        ref_s = s;
        L = int'(pt_mem[0]);
        ref_ct[0] = pt_mem[0];
        a = 8'd0;
        b = 8'd0;
        for (int n = 1; n <= L; n++) begin
            a = a + 8'd1;
            b = b + s[a];
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            t = s[a] + s[b];
            ref_ks[n] = s[t];
            ref_ct[n] = pt_mem[n] ^ s[t];
        end
    endtask

    task automatic start(input logic [23:0] kv);
        int w = 0;
        while (bus.rdy !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        ct_base = ct_wr_cnt;
        s_base  = s_wr_cnt;
        init0   = init_good;
        ord0    = ct_order_err;
        bus.key = kv;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (bus.rdy !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.key = 24'hFFFFFF;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rdy !== 1'b0 || bus.s_wren !== 1'b0 ||
            bus.ct_wren !== 1'b0 || bus.s_addr !== 8'd0 ||
            bus.ct_addr !== 8'd0 || bus.pt_addr !== 8'd0) begin
            errors++;
            $display("FAIL reset_out rdy=%b s_wren=%b ct_wren=%b s_addr=%h want 0",
                     bus.rdy, bus.s_wren, bus.ct_wren, bus.s_addr);
        end
        rst = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy got %b want 1", bus.rdy);
        end
    endtask

    task automatic test_standard;
        int cyc;
        load_pt("Plaintext");
        start(24'h4B6579);
        wait_done(cyc);
        checks++;
        if (cyc > 1539 + 8*9) begin
            errors++;
            $display("FAIL std_latency got %0d want <= %0d", cyc, 1539 + 8*9);
        end
        checks++;
        if (ct_wr_cnt - ct_base != 10) begin
            errors++;
            $display("FAIL std_ct_writes got %0d want 10", ct_wr_cnt - ct_base);
        end
        for (int n = 0; n < 10; n++) begin
            checks++;
            if (ct_mem[n] !== exp_std[n]) begin
                errors++;
                $display("FAIL std_ct[%0d] got %h want %h", n, ct_mem[n], exp_std[n]);
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (ct_wr_cnt - ct_base != 10 || bus.rdy !== 1'b1) begin
            errors++;
            $display("FAIL std_quiet writes=%0d rdy=%b want 10 and 1",
                     ct_wr_cnt - ct_base, bus.rdy);
        end
    endtask

    task automatic test_ksa_len0;
        int cyc, bad;
        load_pt("");
        model(24'h000000);
        start(24'h000000);
        wait_done(cyc);
        checks++;
        if (cyc > 1539) begin
            errors++;
            $display("FAIL ksa_latency got %0d want <= 1539", cyc);
        end
        checks++;
        if (ct_wr_cnt - ct_base != 1 || ct_mem[0] !== 8'h00) begin
            errors++;
            $display("FAIL len0_ct writes=%0d ct0=%h want 1 and 00",
                     ct_wr_cnt - ct_base, ct_mem[0]);
        end
        checks++;
        if (init_good - init0 != 256) begin
            errors++;
            $display("FAIL init_writes got %0d want 256", init_good - init0);
        end
        checks++;
        if (s_wr_cnt - s_base != 768) begin
            errors++;
            $display("FAIL s_writes got %0d want 768", s_wr_cnt - s_base);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_mem[n] !== ref_s[n]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ksa_perm got %0d wrong bytes want 0 (S[0]=%h want %h)",
                     bad, s_mem[0], ref_s[0]);
        end
    endtask

    task automatic test_roundtrip;
        int cyc, bad;
        logic [7:0] rec;
        load_pt("In a hole in the ground there lived a hobbit.");
        model(24'h000001);
        start(24'h000001);
        wait_done(cyc);
        checks++;
        if (ct_mem[0] !== 8'h2D || ct_wr_cnt - ct_base != 46) begin
            errors++;
            $display("FAIL rt_len ct0=%h writes=%0d want 2d and 46",
                     ct_mem[0], ct_wr_cnt - ct_base);
        end
        bad = 0;
        for (int n = 1; n <= 45; n++) begin
            rec = ct_mem[n] ^ ref_ks[n];
            if (rec !== pt_mem[n]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rt_recover got %0d wrong bytes want 0", bad);
        end
    endtask

    task automatic test_len255;
        int cyc, bad;
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'(n);
        model(24'h4B6579);
        start(24'h4B6579);
        wait_done(cyc);
        checks++;
        if (cyc > 1539 + 8*255) begin
            errors++;
            $display("FAIL l255_latency got %0d want <= %0d", cyc, 1539 + 8*255);
        end
        checks++;
        if (ct_wr_cnt - ct_base != 256 || ct_order_err - ord0 != 0) begin
            errors++;
            $display("FAIL l255_addrs writes=%0d order_errs=%0d want 256 and 0",
                     ct_wr_cnt - ct_base, ct_order_err - ord0);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (ct_mem[n] !== ref_ct[n]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL l255_ct got %0d wrong bytes want 0 (ct[255]=%h want %h)",
                     bad, ct_mem[255], ref_ct[255]);
        end
    endtask

    task automatic test_abort_busy;
        int cyc, snap, bad;
        load_pt("Plaintext");
        start(24'h4B6579);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.s_wren !== 1'b0 || bus.ct_wren !== 1'b0 || bus.rdy !== 1'b0) begin
            errors++;
            $display("FAIL abort_out s_wren=%b ct_wren=%b rdy=%b want 0 0 0",
                     bus.s_wren, bus.ct_wren, bus.rdy);
        end
        snap = s_wr_cnt + ct_wr_cnt;
        @(negedge clk);
        checks++;
        if (s_wr_cnt + ct_wr_cnt != snap) begin
            errors++;
            $display("FAIL abort_writes got %0d extra want 0", s_wr_cnt + ct_wr_cnt - snap);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rdy !== 1'b1) begin
            errors++;
            $display("FAIL abort_rdy got %b want 1", bus.rdy);
        end
        start(24'h4B6579);
        repeat (20) @(negedge clk);
        bus.key = 24'h000000;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        wait_done(cyc);
        bad = 0;
        for (int n = 0; n < 10; n++) if (ct_mem[n] !== exp_std[n]) bad++;
        checks++;
        if (bad != 0 || ct_wr_cnt - ct_base != 10) begin
            errors++;
            $display("FAIL busy_ct wrong=%0d writes=%0d want 0 and 10",
                     bad, ct_wr_cnt - ct_base);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bad;
        load_pt("Plaintext");
        start(24'h4B6579);
        bus.en = 1'b1;
        wait_done(cyc);
        bad = 0;
        for (int n = 0; n < 10; n++) if (ct_mem[n] !== exp_std[n]) bad++;
        checks++;
        if (bad != 0 || ct_wr_cnt - ct_base != 10) begin
            errors++;
            $display("FAIL b2b_first wrong=%0d writes=%0d want 0 and 10",
                     bad, ct_wr_cnt - ct_base);
        end
        ct_base = ct_wr_cnt;
        @(negedge clk);
        bus.en = 1'b0;
        checks++;
        if (bus.rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart rdy got %b want 0", bus.rdy);
        end
        wait_done(cyc);
        bad = 0;
        for (int n = 0; n < 10; n++) if (ct_mem[n] !== exp_std[n]) bad++;
        checks++;
        if (bad != 0 || ct_wr_cnt - ct_base != 10) begin
            errors++;
            $display("FAIL b2b_second wrong=%0d writes=%0d want 0 and 10",
                     bad, ct_wr_cnt - ct_base);
        end
    endtask

    initial begin
        bus.en  = 1'b0;
        bus.key = 24'h0;
        @(negedge clk);
        test_reset();
        test_standard();
        test_ksa_len0();
        test_roundtrip();
        test_len255();
        test_abort_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
